// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths and load/store size codes.
package mips_pkg;
  localparam int NB           = 32;
  localparam int NB_REGS      = 5;
  localparam int NB_SIZE_TYPE = 3;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd3;
endpackage

// File: rtl/data_memory.sv
// Byte-enable register array with async clear, one write port and two
// combinational read ports (pipeline and debug).
module data_memory #(
  parameter int NB        = 32,
  parameter int MEM_DEPTH = 32,
  parameter int NB_ADDR   = 5
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_we,
  input  logic [NB/8-1:0]    i_be,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB-1:0]      i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB-1:0]      o_rdata,
  output logic [NB-1:0]      o_dbg_data
);
  localparam int NB_LANES = NB / 8;

  logic [NB-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < NB_LANES; b++) begin
        if (i_be[b]) begin
          mem_q[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata    = mem_q[i_raddr];
  assign o_dbg_data = mem_q[i_dbg_addr];
endmodule

// File: rtl/mem_stage.sv
// MEM stage: alignment check, store lane merge, load extraction/extension,
// sticky misalignment flag and branch resolution around data_memory.
module mem_stage #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_REGS      = 5,
  parameter int MEM_DEPTH    = 32,
  parameter int NB_ADDR      = 5
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_step,
  input  logic [NB-1:0]           i_alu_result,
  input  logic [NB-1:0]           i_data_b_to_write,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic                    i_signed,
  input  logic                    i_cero,
  input  logic                    i_branch,
  input  logic                    i_mem_to_reg,
  input  logic                    i_reg_write,
  input  logic [NB_REGS-1:0]      i_reg_dir_to_write,
  input  logic [NB_ADDR-1:0]      i_debug_addr,
  output logic [NB-1:0]           o_read_data,
  output logic [NB-1:0]           o_alu_result,
  output logic                    o_mem_to_reg,
  output logic                    o_reg_write,
  output logic [NB_REGS-1:0]      o_reg_dir_to_write,
  output logic                    o_pc_src,
  output logic                    o_misaligned,
  output logic [NB-1:0]           o_debug_data
);
  import mips_pkg::*;

  localparam int NB_LANES = NB / 8;

  logic [1:0]          lane;
  logic [NB_ADDR-1:0]  word_idx;
  logic                is_byte, is_half;
  logic                aligned;
  logic                do_write;
  logic [NB_LANES-1:0] be;
  logic [NB-1:0]       wdata;
  logic [NB-1:0]       rdata;
  logic [NB-1:0]       shifted;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic                misaligned_q, misaligned_d;

  assign lane     = i_alu_result[1:0];
  assign word_idx = i_alu_result[NB_ADDR+1:2];
  assign is_byte  = (i_word_size == NB_SIZE_TYPE'(SIZE_BYTE));
  assign is_half  = (i_word_size == NB_SIZE_TYPE'(SIZE_HALF));

  // Any code other than byte/half is handled as a full word.
  assign aligned  = is_byte || (is_half ? !lane[0] : (lane == 2'd0));
  assign do_write = i_mem_write && i_step && aligned;

  always_comb begin
    be    = '1;
    wdata = i_data_b_to_write;
    if (is_byte) begin
      be    = NB_LANES'(1) << lane;
      wdata = {NB_LANES{i_data_b_to_write[7:0]}};
    end else if (is_half) begin
      be    = NB_LANES'(3) << lane;
      wdata = {(NB_LANES/2){i_data_b_to_write[15:0]}};
    end
  end

  data_memory #(
    .NB        (NB),
    .MEM_DEPTH (MEM_DEPTH),
    .NB_ADDR   (NB_ADDR)
  ) u_data_memory (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_we       (do_write),
    .i_be       (be),
    .i_waddr    (word_idx),
    .i_wdata    (wdata),
    .i_raddr    (word_idx),
    .i_dbg_addr (i_debug_addr),
    .o_rdata    (rdata),
    .o_dbg_data (o_debug_data)
  );

  assign shifted = rdata >> {lane, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = shifted[15:0];

  always_comb begin
    o_read_data = '0;
    if (i_mem_read && aligned) begin
      if (is_byte) begin
        o_read_data = {{(NB-8){i_signed & byte_v[7]}}, byte_v};
      end else if (is_half) begin
        o_read_data = {{(NB-16){i_signed & half_v[15]}}, half_v};
      end else begin
        o_read_data = rdata;
      end
    end
  end

  assign misaligned_d = misaligned_q |
                        (i_step && (i_mem_read || i_mem_write) && !aligned);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign o_misaligned       = misaligned_q;
  assign o_alu_result       = i_alu_result;
  assign o_mem_to_reg       = i_mem_to_reg;
  assign o_reg_write        = i_reg_write;
  assign o_reg_dir_to_write = i_reg_dir_to_write;
  assign o_pc_src           = i_branch & i_cero;
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. It owns the data memory (register-based, byte-addressable, little-endian) and performs byte/halfword/word loads with sign or zero extension and stores with byte-lane merge. It resolves branch taken/not-taken for the fetch stage and exposes a debug read port for the debug unit. Memory updates and the misalignment flag are gated by `i_step`.

## Interface
Parameters:
- `NB`, 32, datapath width
- `NB_SIZE_TYPE`, 3, access-size code width
- `NB_REGS`, 5, register-address width
- `MEM_DEPTH`, 32, number of 32-bit words in data memory (power of two)
- `NB_ADDR`, 5, log2(MEM_DEPTH), word-index width

Ports:
- `i_clk`  in  1  stage clock; memory writes on rising edge
- `i_reset_n`  in  1  asynchronous, active-low reset
- `i_step`  in  1  advance enable; when low no state changes
- `i_alu_result`  in  NB  byte address for loads/stores; pass-through for WB
- `i_data_b_to_write`  in  NB  store data (low bytes used for sb/sh)
- `i_mem_read`, `i_mem_write`  in  1  access strobes (never both high; if both, write wins, read data still driven)
- `i_word_size`  in  NB_SIZE_TYPE  0 = byte, 1 = half, 3 = word; other codes treated as word
- `i_signed`  in  1  1 = sign-extend loads, 0 = zero-extend
- `i_cero`, `i_branch`  in  1  ALU zero flag, branch instruction
- `i_mem_to_reg`, `i_reg_write`  in  1  WB controls, passed through
- `i_reg_dir_to_write`  in  NB_REGS  destination register, passed through
- `i_debug_addr`  in  NB_ADDR  debug word index
- `o_read_data`  out  NB  extended load result
- `o_alu_result`  out  NB  pass-through
- `o_mem_to_reg`, `o_reg_write`  out  1  pass-through
- `o_reg_dir_to_write`  out  NB_REGS  pass-through
- `o_pc_src`  out  1  `i_branch & i_cero`
- `o_misaligned`  out  1  sticky misaligned-access flag
- `o_debug_data`  out  NB  raw word at `i_debug_addr`

## Operation
- Word index = `i_alu_result[NB_ADDR+1:2]`; upper address bits ignored, so addresses wrap modulo 4·MEM_DEPTH. Byte lane = `i_alu_result[1:0]`.
- Alignment: half requires lane[0]=0; word requires lane=0; byte is always aligned.
- Store (`i_mem_write & i_step`, aligned): byte writes lane `a` with `data[7:0]`; half writes lanes a, a+1 with `data[15:0]`; word writes all four lanes. Untouched lanes keep their value.
- Misaligned store: memory unchanged, `o_misaligned` set.
- Load (`i_mem_read`, aligned): select byte/half at lane, extend to NB per `i_signed`; word returned as-is. Misaligned load: `o_read_data` = 0; `o_misaligned` set if `i_step`.
- `o_read_data` = 0 when `i_mem_read` is low.
- `o_misaligned` stays set until reset; no other clear.
- Pass-through outputs and `o_pc_src` are combinational copies of their inputs.

## Timing
- Reset (`i_reset_n` low, async): all memory words = 0, `o_misaligned` = 0, immediately, regardless of clock. Combinational outputs follow inputs/memory (0 read data while memory is zero).
- EX/MEM updates on falling edge; stores commit on the following rising edge (half-cycle setup).
- Load and debug read are combinational from the array: zero cycles of latency. A load to the word stored in the same cycle returns the old value until the rising edge, then the new value.
- `o_misaligned` rises at the rising edge of the offending access cycle.
- `i_step` low: no write, no flag update; reads remain live.
- Reset release mid-access: the first rising edge after deassertion with `i_step` high performs the access normally.

## Structure
- Shared package `mips_pkg`: size codes (`SIZE_BYTE` = 0, `SIZE_HALF` = 1, `SIZE_WORD` = 3), `NB`, `NB_REGS`, `NB_SIZE_TYPE`.
- Sub-module `data_memory`: byte-enable register array with async clear, one write port, two combinational read ports (pipeline, debug). Alignment, lane merge and extension logic stay in `mem_stage`.

## Test plan
- Reset, then `sw` 0xDEADBEEF to addr 0x8 → `o_read_data` on `lw` 0x8 = 0xDEADBEEF; `o_debug_data` at index 2 = 0xDEADBEEF.
- `sb` 0x7F at addr 0x9 over 0xDEADBEEF → word = 0xDEAD7FEF; `lb` signed at 0xB = 0xFFFFFFDE; `lbu` = 0x000000DE.
- `sh` 0x8001 at addr 0x2 → `lh` signed at 0x2 = 0xFFFF8001, `lhu` = 0x00008001, lanes 0–1 unchanged.
- `lw` at 0x6 with step → `o_read_data` = 0, `o_misaligned` = 1 after edge; a following `sh` at 0x3 leaves memory unchanged; flag stays 1.
- `sw` with `i_step` = 0 → memory unchanged, flag unchanged; address 0x88 (DEPTH 32) aliases word 2.
- Write several words, pulse `i_reset_n` low between clock edges → memory and flag clear at once; `i_branch` = `i_cero` = 1 → `o_pc_src` = 1.
